striping_sched: RTL and testbench

Lane scheduler for the two-lane striping datapath. Accepts 32-bit words from the upstream source through a valid/ready handshake. Assigns each accepted word to lane 0 or lane 1 in strict alternation, or to lane 0 only in single-lane mode. Gates every transfer on per-lane credits returned by the downstream lane buffers. Its outputs drive the striping demux's data, valid and lane-select inputs in the clk_2f domain.

---
 rtl/striping_sched.sv | 123 ++++++++++++
 tb/tb_striping_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/striping_sched.sv
// Two-lane striping scheduler: strict lane alternation (or lane 0 only),
// credit-gated valid/ready acceptance, one-cycle registered issue to the demux.
module striping_sched #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk_2f,
  input  logic          reset_L,
  input  logic [31:0]   data_in,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic          dual_lane,
  input  logic          credit_ret_0,
  input  logic          credit_ret_1,
  output logic [31:0]   data_out,
  output logic          valid_out,
  output logic          lane_sel,
  output logic [CW-1:0] credit_cnt_0,
  output logic [CW-1:0] credit_cnt_1,
  output logic          err_credit
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    NEXT0 = 2'd1,
    NEXT1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_r;
  logic [CW-1:0] cnt0_r;
  logic [CW-1:0] cnt1_r;
  logic [31:0]   data_r;
  logic          valid_r;
  logic          lane_r;
  logic          err_r;
  logic          ready_s;
  logic          xfer_s;
  logic          take0_s;
  logic          take1_s;
  logic          ovf0_s;
  logic          ovf1_s;

  // A simultaneous take and return cancel; a return at full credit saturates.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                input logic take,
                                                input logic ret);
    logic [CW-1:0] nxt;
    if (take && !ret) begin
      nxt = cnt - ONE;
    end else if (ret && !take && (cnt != CMAX)) begin
      nxt = cnt + ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Acceptance depends only on registered state and credits of the target lane.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      NEXT0:   ready_s = (cnt0_r != ZERO);
      NEXT1:   ready_s = (cnt1_r != ZERO);
      default: ready_s = 1'b0;
    endcase
    xfer_s  = valid_in && ready_s;
    take0_s = xfer_s && (state_r == NEXT0);
    take1_s = xfer_s && (state_r == NEXT1);
    ovf0_s  = credit_ret_0 && !take0_s && (cnt0_r == CMAX);
    ovf1_s  = credit_ret_1 && !take1_s && (cnt1_r == CMAX);
  end

  // Lane-order FSM; dual_lane only matters when leaving NEXT0 so pairs complete.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= INIT;
    end else begin
      case (state_r)
        INIT:    state_r <= NEXT0;
        NEXT0:   state_r <= (take0_s && dual_lane) ? NEXT1 : NEXT0;
        NEXT1:   state_r <= take1_s ? NEXT0 : NEXT1;
        default: state_r <= INIT;
      endcase
    end
  end

  // Credit counters, sticky overflow flag and the registered issue stage.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      cnt0_r  <= CMAX;
      cnt1_r  <= CMAX;
      err_r   <= 1'b0;
      data_r  <= 32'd0;
      valid_r <= 1'b0;
      lane_r  <= 1'b0;
    end else begin
      cnt0_r  <= credit_next(cnt0_r, take0_s, credit_ret_0);
      cnt1_r  <= credit_next(cnt1_r, take1_s, credit_ret_1);
      err_r   <= err_r || ovf0_s || ovf1_s;
      valid_r <= xfer_s;
      if (xfer_s) begin
        data_r <= data_in;
        lane_r <= take1_s;
      end else begin
        data_r <= data_r;
        lane_r <= lane_r;
      end
    end
  end

  assign ready_out    = ready_s;
  assign data_out     = data_r;
  assign valid_out    = valid_r;
  assign lane_sel     = lane_r;
  assign credit_cnt_0 = cnt0_r;
  assign credit_cnt_1 = cnt1_r;
  assign err_credit   = err_r;

endmodule

// File: tb/tb_striping_sched.sv
// Self-checking bench for striping_sched: a reference model predicts ready,
// credits and issued words; issued words go through a scoreboard queue.
module tb_striping_sched;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  logic          clk_2f = 1'b0;
  logic          reset_L;
  logic [31:0]   data_in;
  logic          valid_in;
  logic          ready_out;
  logic          dual_lane;
  logic          credit_ret_0;
  logic          credit_ret_1;
  logic [31:0]   data_out;
  logic          valid_out;
  logic          lane_sel;
  logic [CW-1:0] credit_cnt_0;
  logic [CW-1:0] credit_cnt_1;
  logic          err_credit;

  striping_sched #(.CREDITS(CREDITS), .CW(CW)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .dual_lane(dual_lane), .credit_ret_0(credit_ret_0),
    .credit_ret_1(credit_ret_1), .data_out(data_out), .valid_out(valid_out),
    .lane_sel(lane_sel), .credit_cnt_0(credit_cnt_0), .credit_cnt_1(credit_cnt_1),
    .err_credit(err_credit)
  );

  always #5 clk_2f = ~clk_2f;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_state;
  int          m_c0;
  int          m_c1;
  logic        m_err;
  logic        m_ready;
  logic        m_xfer;
  logic        dut_ready;
  logic [32:0] sb[$];
  logic [32:0] exp_w;

  task automatic model_reset();
    m_state = 0;
    m_c0    = CREDITS;
    m_c1    = CREDITS;
    m_err   = 1'b0;
    m_xfer  = 1'b0;
    m_ready = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: apply inputs at negedge, predict, sample after posedge.
  task automatic drive(input logic v, input logic [31:0] d, input logic dl,
                       input logic r0, input logic r1);
    int   nc0;
    int   nc1;
    int   ns;
    logic t0;
    logic t1;
    @(negedge clk_2f);
    valid_in = v; data_in = d; dual_lane = dl;
    credit_ret_0 = r0; credit_ret_1 = r1;
    #1 dut_ready = ready_out;
    m_ready = (m_state == 1 && m_c0 > 0) || (m_state == 2 && m_c1 > 0);
    m_xfer  = v && m_ready;
    t0 = m_xfer && (m_state == 1);
    t1 = m_xfer && (m_state == 2);
    if (m_xfer) sb.push_back({t1, d});
    nc0 = m_c0;
    if (t0 && !r0) nc0 = nc0 - 1;
    else if (r0 && !t0) begin
      if (m_c0 == CREDITS) m_err = 1'b1; else nc0 = nc0 + 1;
    end
    nc1 = m_c1;
    if (t1 && !r1) nc1 = nc1 - 1;
    else if (r1 && !t1) begin
      if (m_c1 == CREDITS) m_err = 1'b1; else nc1 = nc1 + 1;
    end
    case (m_state)
      0:       ns = 1;
      1:       ns = (m_xfer && dl) ? 2 : 1;
      2:       ns = m_xfer ? 1 : 2;
      default: ns = 0;
    endcase
    @(posedge clk_2f);
    #1;
    m_state = ns; m_c0 = nc0; m_c1 = nc1;
    credit_ret_0 = 1'b0; credit_ret_1 = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; valid_in = 1'b0; data_in = 32'd0; dual_lane = 1'b1;
    credit_ret_0 = 1'b0; credit_ret_1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    n_vec++;
    if ({valid_out, ready_out, lane_sel, err_credit, data_out} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outs: got v=%b rdy=%b lane=%b err=%b data=%h want all 0",
               valid_out, ready_out, lane_sel, err_credit, data_out);
    end
    n_vec++;
    if (credit_cnt_0 !== 3'd4 || credit_cnt_1 !== 3'd4) begin
      n_err++;
      $display("FAIL reset_credits: got %0d/%0d want 4/4", credit_cnt_0, credit_cnt_1);
    end
    @(posedge clk_2f);
    #2 reset_L = 1'b1;
  endtask

  task automatic test_stripe();
    logic [31:0] w = 32'd1;
    int nx = 0;
    for (int cyc = 0; cyc < 20 && nx < 6; cyc++) begin
      drive(1'b1, w, 1'b1, 1'b0, 1'b0);
      if (cyc == 0) begin
        n_vec++;
        if (dut_ready !== 1'b0) begin
          n_err++; $display("FAIL stripe_first_ready: got %b want 0", dut_ready);
        end
      end
      n_vec++;
      if (dut_ready !== m_ready) begin
        n_err++; $display("FAIL stripe_ready: got %b want %b", dut_ready, m_ready);
      end
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL stripe_out: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
        w = w + 32'd1;
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL stripe_idle: valid_out got %b want 0", valid_out);
      end
      if (valid_out === 1'b1) begin
        n_vec++;
        if (lane_sel !== nx[0]) begin
          n_err++; $display("FAIL stripe_lane: word %0d got lane %b want %b", nx, lane_sel, nx[0]);
        end
        nx++;
      end
    end
    n_vec++;
    if (credit_cnt_0 !== 3'd1 || credit_cnt_1 !== 3'd1 || nx != 6) begin
      n_err++;
      $display("FAIL stripe_credits: got %0d/%0d after %0d words want 1/1 after 6",
               credit_cnt_0, credit_cnt_1, nx);
    end
    repeat (3) drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (int'(credit_cnt_0) !== m_c0 || int'(credit_cnt_1) !== m_c1 || err_credit !== m_err) begin
      n_err++;
      $display("FAIL stripe_restore: got %0d/%0d err=%b want %0d/%0d err=%b",
               credit_cnt_0, credit_cnt_1, err_credit, m_c0, m_c1, m_err);
    end
  endtask

  task automatic test_exhaust();
    logic [31:0] w = 32'd1;
    logic [31:0] wds [4] = '{32'd9, 32'd9, 32'd9, 32'd10};
    logic        r0s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        r1s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int nx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(1'b1, w, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL exhaust_out: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
        w = w + 32'd1;
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL exhaust_idle: valid_out got %b want 0", valid_out);
      end
      if (valid_out === 1'b1) nx++;
    end
    n_vec++;
    if (nx != 8 || ready_out !== 1'b0 || credit_cnt_0 !== 3'd0) begin
      n_err++;
      $display("FAIL exhaust_stall: got %0d xfers rdy=%b c0=%0d want 8 rdy=0 c0=0",
               nx, ready_out, credit_cnt_0);
    end
    // ret_1 alone, then ret_0, then word 9 on lane 0 and word 10 on lane 1
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, wds[k], 1'b1, r0s[k], r1s[k]);
      n_vec++;
      if (dut_ready !== m_ready) begin
        n_err++; $display("FAIL exhaust_ready%0d: got %b want %b", k, dut_ready, m_ready);
      end
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL exhaust_resume%0d: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   k, valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL exhaust_hold%0d: valid_out got %b want 0", k, valid_out);
      end
      if (k == 2) begin
        n_vec++;
        if ({valid_out, lane_sel, data_out} !== {1'b1, 1'b0, 32'd9}) begin
          n_err++;
          $display("FAIL exhaust_word9: got v=%b lane=%b data=%h want v=1 lane=0 data=00000009",
                   valid_out, lane_sel, data_out);
        end
      end
    end
    repeat (4) drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (credit_cnt_0 !== 3'd4 || credit_cnt_1 !== 3'd4 || err_credit !== 1'b0) begin
      n_err++;
      $display("FAIL exhaust_restore: got %0d/%0d err=%b want 4/4 err=0",
               credit_cnt_0, credit_cnt_1, err_credit);
    end
  endtask

  task automatic test_single();
    logic [31:0] w = 32'h100;
    int nx = 0;
    int n1 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(w < 32'h105, w, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL single_out: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
        w = w + 32'd1;
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL single_idle: valid_out got %b want 0", valid_out);
      end
      if (valid_out === 1'b1) begin
        nx++;
        if (lane_sel === 1'b1) n1++;
      end
    end
    n_vec++;
    if (nx != 4 || n1 != 0 || credit_cnt_1 !== 3'd4 || ready_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_stall: got %0d xfers %0d on lane1 c1=%0d rdy=%b want 4 0 4 0",
               nx, n1, credit_cnt_1, ready_out);
    end
    repeat (4) drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mode_change();
    logic dls  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic lanes[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h200 + 32'(k), dls[k], 1'b0, 1'b0);
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL mode_out%0d: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   k, valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
      end else begin
        n_err++; $display("FAIL mode_stall%0d: got no transfer want transfer", k);
      end
      n_vec++;
      if (lane_sel !== lanes[k]) begin
        n_err++; $display("FAIL mode_lane%0d: got %b want %b", k, lane_sel, lanes[k]);
      end
    end
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (credit_cnt_0 !== 3'd4 || credit_cnt_1 !== 3'd4) begin
      n_err++;
      $display("FAIL mode_restore: got %0d/%0d want 4/4", credit_cnt_0, credit_cnt_1);
    end
  endtask

  task automatic test_credit_edge();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h301, 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) exp_w = sb.pop_front();
    drive(1'b1, 32'h302, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (sb.size() != 1) begin
      n_err++; $display("FAIL edge_model: queue got %0d want 1", sb.size());
    end else begin
      exp_w = sb.pop_front();
      if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
        n_err++;
        $display("FAIL edge_out: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                 valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
      end
    end
    n_vec++;
    if (credit_cnt_0 !== 3'd2 || credit_cnt_1 !== 3'd4 || err_credit !== 1'b1) begin
      n_err++;
      $display("FAIL edge_credits: got %0d/%0d err=%b want 2/4 err=1",
               credit_cnt_0, credit_cnt_1, err_credit);
    end
    repeat (2) drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (credit_cnt_0 !== 3'd4 || err_credit !== 1'b1) begin
      n_err++;
      $display("FAIL edge_sticky: got c0=%0d err=%b want c0=4 err=1", credit_cnt_0, err_credit);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h400 + 32'(k), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (m_xfer) begin
        exp_w = sb.pop_front();
        if ({valid_out, lane_sel, data_out} !== {1'b1, exp_w}) begin
          n_err++;
          $display("FAIL rmid_out%0d: got v=%b lane=%b data=%h want v=1 lane=%b data=%h",
                   k, valid_out, lane_sel, data_out, exp_w[32], exp_w[31:0]);
        end
      end else begin
        n_err++; $display("FAIL rmid_stall%0d: got no transfer want transfer", k);
      end
    end
    n_vec++;
    if (credit_cnt_0 !== 3'd1 || credit_cnt_1 !== 3'd2) begin
      n_err++; $display("FAIL rmid_pre: got %0d/%0d want 1/2", credit_cnt_0, credit_cnt_1);
    end
    data_in = 32'h405;
    #2 reset_L = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || ready_out !== 1'b0 || err_credit !== 1'b0 ||
        credit_cnt_0 !== 3'd4 || credit_cnt_1 !== 3'd4) begin
      n_err++;
      $display("FAIL rmid_async: got v=%b rdy=%b err=%b c=%0d/%0d want 0 0 0 4/4",
               valid_out, ready_out, err_credit, credit_cnt_0, credit_cnt_1);
    end
    model_reset();
    @(posedge clk_2f);
    #2 reset_L = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (dut_ready !== (k == 1)) begin
        n_err++; $display("FAIL rmid_ready%0d: got %b want %b", k, dut_ready, (k == 1));
      end
    end
    n_vec++;
    if ({valid_out, lane_sel, data_out} !== {1'b1, 1'b0, 32'h500}) begin
      n_err++;
      $display("FAIL rmid_first: got v=%b lane=%b data=%h want v=1 lane=0 data=00000500",
               valid_out, lane_sel, data_out);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_stripe();
    test_exhaust();
    test_single();
    test_mode_change();
    test_credit_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
